alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq_pkg.sv | 39 +++
 rtl/alu_seq_if.sv | 34 +++
 rtl/alu_seq_muldiv.sv | 102 ++++++++++
 rtl/alu_seq.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_seq.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/alu_seq_pkg.sv
// Shared types for the sequential ALU: op-code and FSM state encodings.
package alu_seq_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_PASS = 5'd0,
    OP_AND  = 5'd1,
    OP_OR   = 5'd2,
    OP_NOT  = 5'd3,
    OP_XOR  = 5'd4,
    OP_ADD  = 5'd5,
    OP_SUB  = 5'd6,
    OP_SWAP = 5'd7,
    OP_SHL  = 5'd8,
    OP_RLC  = 5'd9,
    OP_SHR  = 5'd10,
    OP_RRC  = 5'd11,
    OP_INC  = 5'd12,
    OP_DEC  = 5'd13,
    OP_CLR  = 5'd14,
    OP_SET  = 5'd15,
    OP_ADC  = 5'd16,
    OP_SBB  = 5'd17,
    OP_MUL  = 5'd18,
    OP_DIV  = 5'd19
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_multi(input logic [OP_W-1:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/result handshake bundle between an ALU client (master) and alu_seq (slave).
interface alu_seq_if #(parameter int WIDTH = 8);
  import alu_seq_pkg::*;

  localparam int NW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [NW-1:0]    n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Y;
  logic [WIDTH-1:0] Y_hi;
  logic             C;
  logic             Z;
  logic             N;
  logic             V;
  logic             DZ;
  logic             ERR;

  modport master (
    output in_valid, op, A, B, n, out_ready,
    input  in_ready, out_valid, Y, Y_hi, C, Z, N, V, DZ, ERR
  );

  modport slave (
    input  in_valid, op, A, B, n, out_ready,
    output in_ready, out_valid, Y, Y_hi, C, Z, N, V, DZ, ERR
  );

endinterface

// File: rtl/alu_seq_muldiv.sv
// Iterative WIDTH-step engine: shift-add unsigned multiply and restoring unsigned divide.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int NW = $clog2(WIDTH);
  localparam logic [NW-1:0] LAST = NW'(WIDTH - 1);

  logic             busy_q, busy_d;
  logic             div_q, div_d;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] opd_q, opd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   shl_s;
  logic             ge_s;
  logic [WIDTH-1:0] sub_s;
  logic [WIDTH-1:0] step_hi_s;
  logic [WIDTH-1:0] step_lo_s;
  logic             last_s;

  assign last_s = busy_q && (cnt_q == LAST);

  // One iteration of the selected algorithm; the final step is consumed combinationally by the top.
  always_comb begin
    sum_s = {1'b0, hi_q} + {1'b0, (lo_q[0] ? opd_q : {WIDTH{1'b0}})};
    shl_s = {hi_q, lo_q[WIDTH-1]};
    ge_s  = (shl_s >= {1'b0, opd_q});
    // When ge_s holds the true difference is below opd_q, so WIDTH bits suffice.
    sub_s = shl_s[WIDTH-1:0] - opd_q;
    if (div_q) begin
      step_hi_s = ge_s ? sub_s : shl_s[WIDTH-1:0];
      step_lo_s = {lo_q[WIDTH-2:0], ge_s};
    end else begin
      step_hi_s = sum_s[WIDTH:1];
      step_lo_s = {sum_s[0], lo_q[WIDTH-1:1]};
    end
  end

  // Operand load on start, then one step per cycle until the last one.
  always_comb begin
    busy_d = busy_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    opd_d  = opd_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (start_i) begin
      busy_d = 1'b1;
      div_d  = div_i;
      cnt_d  = {NW{1'b0}};
      opd_d  = div_i ? b_i : a_i;
      hi_d   = {WIDTH{1'b0}};
      lo_d   = div_i ? a_i : b_i;
    end else if (busy_q) begin
      busy_d = !last_s;
      cnt_d  = cnt_q + {{(NW-1){1'b0}}, 1'b1};
      hi_d   = step_hi_s;
      lo_d   = step_lo_s;
    end else begin
      busy_d = 1'b0;
    end
  end

  // Engine state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= {NW{1'b0}};
      opd_q  <= {WIDTH{1'b0}};
      hi_q   <= {WIDTH{1'b0}};
      lo_q   <= {WIDTH{1'b0}};
    end else begin
      busy_q <= busy_d;
      div_q  <= div_d;
      cnt_q  <= cnt_d;
      opd_q  <= opd_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
    end
  end

  assign busy_o = busy_q;
  assign done_o = last_s;
  assign hi_o   = step_hi_s;
  assign lo_o   = step_lo_s;

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops computed at acceptance, MUL/DIV delegated to alu_seq_muldiv.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam int HW = WIDTH / 2;

  state_e           state_q, state_d;
  logic             cf_q, cf_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] yhi_q, yhi_d;
  logic             z_q, z_d;
  logic             neg_q, neg_d;
  logic             v_q, v_d;
  logic             dz_q, dz_d;
  logic             err_q, err_d;
  logic             dzp_q, dzp_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [WIDTH:0]   wide_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_cf_s;
  logic             alu_v_s;
  logic             alu_err_s;
  logic             cin_s;
  logic [WIDTH-1:0] onehot_s;
  logic             accept_s;
  logic             md_start_s;
  logic             md_busy_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [WIDTH-1:0] md_lo_s;

  assign accept_s = bus.in_valid && in_ready_q;
  assign cin_s    = ((bus.op == OP_ADC) || (bus.op == OP_SBB)) ? cf_q : 1'b0;
  assign onehot_s = {{(WIDTH-1){1'b0}}, 1'b1} << bus.n;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (md_start_s),
    .div_i   (bus.op == OP_DIV),
    .a_i     (bus.A),
    .b_i     (bus.B),
    .busy_o  (md_busy_s),
    .done_o  (md_done_s),
    .hi_o    (md_hi_s),
    .lo_o    (md_lo_s)
  );

  // Single-cycle result and carry/overflow from the operands presented at acceptance.
  always_comb begin
    wide_s    = {(WIDTH+1){1'b0}};
    alu_y_s   = {WIDTH{1'b0}};
    alu_cf_s  = cf_q;
    alu_v_s   = 1'b0;
    alu_err_s = 1'b0;
    case (bus.op)
      OP_PASS: alu_y_s = bus.B;
      OP_AND:  alu_y_s = bus.A & bus.B;
      OP_OR:   alu_y_s = bus.A | bus.B;
      OP_NOT:  alu_y_s = ~bus.B;
      OP_XOR:  alu_y_s = bus.A ^ bus.B;
      OP_ADD, OP_ADC: begin
        wide_s   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin_s};
        alu_y_s  = wide_s[WIDTH-1:0];
        alu_cf_s = wide_s[WIDTH];
        alu_v_s  = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) && (wide_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SUB, OP_SBB: begin
        wide_s   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, cin_s};
        alu_y_s  = wide_s[WIDTH-1:0];
        alu_cf_s = wide_s[WIDTH];
        alu_v_s  = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) && (wide_s[WIDTH-1] != bus.A[WIDTH-1]);
      end
      OP_SWAP: alu_y_s = {bus.B[HW-1:0], bus.B[WIDTH-1:HW]};
      OP_SHL: begin
        alu_y_s  = {bus.B[WIDTH-2:0], 1'b0};
        alu_cf_s = bus.B[WIDTH-1];
      end
      OP_RLC: begin
        alu_y_s  = {bus.B[WIDTH-2:0], cf_q};
        alu_cf_s = bus.B[WIDTH-1];
      end
      OP_SHR: begin
        alu_y_s  = {1'b0, bus.B[WIDTH-1:1]};
        alu_cf_s = bus.B[0];
      end
      OP_RRC: begin
        alu_y_s  = {cf_q, bus.B[WIDTH-1:1]};
        alu_cf_s = bus.B[0];
      end
      OP_INC: begin
        wide_s   = {1'b0, bus.B} + {{WIDTH{1'b0}}, 1'b1};
        alu_y_s  = wide_s[WIDTH-1:0];
        alu_cf_s = wide_s[WIDTH];
      end
      OP_DEC: begin
        wide_s   = {1'b0, bus.B} - {{WIDTH{1'b0}}, 1'b1};
        alu_y_s  = wide_s[WIDTH-1:0];
        alu_cf_s = wide_s[WIDTH];
      end
      OP_CLR:  alu_y_s = bus.A & ~onehot_s;
      OP_SET:  alu_y_s = bus.A | onehot_s;
      OP_MUL, OP_DIV: alu_y_s = {WIDTH{1'b0}};
      default: alu_err_s = 1'b1;
    endcase
  end

  // FSM next state and result-register loads.
  always_comb begin
    state_d    = state_q;
    cf_d       = cf_q;
    y_d        = y_q;
    yhi_d      = yhi_q;
    z_d        = z_q;
    neg_d      = neg_q;
    v_d        = v_q;
    dz_d       = dz_q;
    err_d      = err_q;
    dzp_d      = dzp_q;
    md_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s && is_multi(bus.op)) begin
          state_d    = ST_BUSY;
          md_start_s = 1'b1;
          dzp_d      = (bus.op == OP_DIV) && (bus.B == {WIDTH{1'b0}});
        end else if (accept_s) begin
          state_d = ST_DONE;
          y_d     = alu_y_s;
          yhi_d   = {WIDTH{1'b0}};
          cf_d    = alu_cf_s;
          z_d     = (alu_y_s == {WIDTH{1'b0}});
          neg_d   = alu_y_s[WIDTH-1];
          v_d     = alu_v_s;
          dz_d    = 1'b0;
          err_d   = alu_err_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // Restoring division by zero naturally yields all-ones quotient and remainder A.
        if (md_done_s) begin
          state_d = ST_DONE;
          y_d     = md_lo_s;
          yhi_d   = md_hi_s;
          z_d     = (md_lo_s == {WIDTH{1'b0}});
          neg_d   = md_lo_s[WIDTH-1];
          v_d     = 1'b0;
          dz_d    = dzp_q;
          err_d   = 1'b0;
        end else if (!md_busy_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d  = (state_d == ST_IDLE);
    out_valid_d = (state_d == ST_DONE);
  end

  // State, carry and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cf_q        <= 1'b0;
      y_q         <= {WIDTH{1'b0}};
      yhi_q       <= {WIDTH{1'b0}};
      z_q         <= 1'b0;
      neg_q       <= 1'b0;
      v_q         <= 1'b0;
      dz_q        <= 1'b0;
      err_q       <= 1'b0;
      dzp_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cf_q        <= cf_d;
      y_q         <= y_d;
      yhi_q       <= yhi_d;
      z_q         <= z_d;
      neg_q       <= neg_d;
      v_q         <= v_d;
      dz_q        <= dz_d;
      err_q       <= err_d;
      dzp_q       <= dzp_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.Y         = y_q;
  assign bus.Y_hi      = yhi_q;
  assign bus.C         = cf_q;
  assign bus.Z         = z_q;
  assign bus.N         = neg_q;
  assign bus.V         = v_q;
  assign bus.DZ        = dz_q;
  assign bus.ERR       = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed vector bench for alu_seq at WIDTH=8, plus hold, back-to-back and mid-MUL reset sequences.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8)) bus();

  alu_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // flags = {C, Z, N, V, DZ, ERR}
  typedef struct packed {
    logic [4:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] n;
    logic [7:0] y;
    logic [7:0] yhi;
    logic [5:0] fl;
  } vec_t;

  vec_t vecs [27];

  function automatic logic [5:0] flags_now();
    return {bus.C, bus.Z, bus.N, bus.V, bus.DZ, bus.ERR};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t t, input int idx);
    int lat;
    int rdy_seen;
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk($sformatf("v%0d in_ready_idle", idx), bus.in_ready, 1);
    bus.op = t.op; bus.A = t.a; bus.B = t.b; bus.n = t.n;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.A = ~t.a; bus.B = ~t.b; bus.op = 5'd0; bus.n = ~t.n;
    lat = 1; rdy_seen = 0;
    while (!bus.out_valid && lat < 40) begin
      if (bus.in_ready) rdy_seen++;
      @(negedge clk);
      lat++;
    end
    chk($sformatf("v%0d latency", idx), lat, ((t.op == 5'd18) || (t.op == 5'd19)) ? 9 : 1);
    chk($sformatf("v%0d ready_while_busy", idx), rdy_seen, 0);
    chk($sformatf("v%0d Y", idx), bus.Y, t.y);
    chk($sformatf("v%0d Y_hi", idx), bus.Y_hi, t.yhi);
    chk($sformatf("v%0d flags", idx), flags_now(), t.fl);
    chk($sformatf("v%0d in_ready_done", idx), bus.in_ready, 0);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk($sformatf("v%0d out_valid_drop", idx), bus.out_valid, 0);
    chk($sformatf("v%0d in_ready_back", idx), bus.in_ready, 1);
  endtask

  initial begin
    int late;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.op = 5'd0;
    bus.A = 8'h00; bus.B = 8'h00; bus.n = 3'd0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst out_valid", bus.out_valid, 0);
    chk("rst in_ready", bus.in_ready, 1);
    chk("rst Y", bus.Y, 8'h00);
    chk("rst Y_hi", bus.Y_hi, 8'h00);
    chk("rst flags", flags_now(), 6'b000000);
    rst_n = 1'b1;
    @(negedge clk);

    //            op     A      B      n     Y      Y_hi   CZNVDE
    vecs[0]  = '{5'd5,  8'hFF, 8'h01, 3'd0, 8'h00, 8'h00, 6'b110000};
    vecs[1]  = '{5'd16, 8'h10, 8'h20, 3'd0, 8'h31, 8'h00, 6'b000000};
    vecs[2]  = '{5'd6,  8'h05, 8'h07, 3'd0, 8'hFE, 8'h00, 6'b101000};
    vecs[3]  = '{5'd11, 8'h00, 8'h02, 3'd0, 8'h81, 8'h00, 6'b001000};
    vecs[4]  = '{5'd8,  8'h00, 8'h80, 3'd0, 8'h00, 8'h00, 6'b110000};
    vecs[5]  = '{5'd17, 8'h05, 8'h05, 3'd0, 8'hFF, 8'h00, 6'b101000};
    vecs[6]  = '{5'd5,  8'h7F, 8'h01, 3'd0, 8'h80, 8'h00, 6'b001100};
    vecs[7]  = '{5'd6,  8'h80, 8'h01, 3'd0, 8'h7F, 8'h00, 6'b000100};
    vecs[8]  = '{5'd0,  8'h3C, 8'hA5, 3'd0, 8'hA5, 8'h00, 6'b001000};
    vecs[9]  = '{5'd1,  8'h3C, 8'hA5, 3'd0, 8'h24, 8'h00, 6'b000000};
    vecs[10] = '{5'd2,  8'h3C, 8'hA5, 3'd0, 8'hBD, 8'h00, 6'b001000};
    vecs[11] = '{5'd4,  8'h3C, 8'hA5, 3'd0, 8'h99, 8'h00, 6'b001000};
    vecs[12] = '{5'd3,  8'h3C, 8'hA5, 3'd0, 8'h5A, 8'h00, 6'b000000};
    vecs[13] = '{5'd7,  8'h00, 8'h12, 3'd0, 8'h21, 8'h00, 6'b000000};
    vecs[14] = '{5'd12, 8'h00, 8'hFF, 3'd0, 8'h00, 8'h00, 6'b110000};
    vecs[15] = '{5'd9,  8'h00, 8'h40, 3'd0, 8'h81, 8'h00, 6'b001000};
    vecs[16] = '{5'd13, 8'h00, 8'h00, 3'd0, 8'hFF, 8'h00, 6'b101000};
    vecs[17] = '{5'd10, 8'h00, 8'h03, 3'd0, 8'h01, 8'h00, 6'b100000};
    vecs[18] = '{5'd14, 8'hFF, 8'h00, 3'd3, 8'hF7, 8'h00, 6'b101000};
    vecs[19] = '{5'd15, 8'h00, 8'h00, 3'd7, 8'h80, 8'h00, 6'b101000};
    vecs[20] = '{5'd18, 8'hFF, 8'hFF, 3'd0, 8'h01, 8'hFE, 6'b100000};
    vecs[21] = '{5'd19, 8'h64, 8'h07, 3'd0, 8'h0E, 8'h02, 6'b100000};
    vecs[22] = '{5'd19, 8'h55, 8'h00, 3'd0, 8'hFF, 8'h55, 6'b101010};
    vecs[23] = '{5'd20, 8'h12, 8'h34, 3'd0, 8'h00, 8'h00, 6'b110001};
    vecs[24] = '{5'd31, 8'hFF, 8'hFF, 3'd0, 8'h00, 8'h00, 6'b110001};
    vecs[25] = '{5'd13, 8'h00, 8'h01, 3'd0, 8'h00, 8'h00, 6'b010000};
    vecs[26] = '{5'd18, 8'h0C, 8'h0B, 3'd0, 8'h84, 8'h00, 6'b001000};

    for (int i = 0; i < 27; i++) run_vec(vecs[i], i);

    // Result held in DONE while inputs toggle, then a request waiting during consume.
    bus.op = 5'd5; bus.A = 8'hFF; bus.B = 8'hFF; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("hold out_valid", bus.out_valid, 1);
    for (int i = 0; i < 3; i++) begin
      bus.op = 5'(i * 7 + 1); bus.A = 8'($urandom); bus.B = 8'($urandom); bus.in_valid = 1'b1;
      @(negedge clk);
      chk($sformatf("hold%0d Y", i), bus.Y, 8'hFE);
      chk($sformatf("hold%0d flags", i), flags_now(), 6'b101000);
      chk($sformatf("hold%0d in_ready", i), bus.in_ready, 0);
      chk($sformatf("hold%0d out_valid", i), bus.out_valid, 1);
    end
    bus.op = 5'd5; bus.A = 8'h01; bus.B = 8'h01; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("consume no_accept", bus.out_valid, 0);
    chk("consume in_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("next out_valid", bus.out_valid, 1);
    chk("next Y", bus.Y, 8'h02);
    chk("next flags", flags_now(), 6'b000000);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    // Set cf, then reset in the fourth BUSY cycle of a MUL.
    run_vec('{5'd12, 8'h00, 8'hFF, 3'd0, 8'h00, 8'h00, 6'b110000}, 100);
    bus.op = 5'd18; bus.A = 8'hFF; bus.B = 8'hFF; bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid busy in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", bus.out_valid, 0);
    chk("mid rst C", bus.C, 0);
    chk("mid rst in_ready", bus.in_ready, 1);
    chk("mid rst Y", bus.Y, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    late = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) late++;
    end
    chk("no late result", late, 0);
    chk("post rst in_ready", bus.in_ready, 1);
    run_vec('{5'd5, 8'h01, 8'h01, 3'd0, 8'h02, 8'h00, 6'b000000}, 101);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
